m6809_bus_fabric: RTL and testbench
===================================

Name: m6809_bus_fabric

Overview:
- Parametrised bus fabric between the m6809 core and N memory/peripheral regions. Generalises the fixed two-way ROM/RAM split.
- Provides mask/base address decode with fixed priority, per-region programmable wait states, and an optional device-acknowledge mode with timeout.
- Unmapped or timed-out accesses complete with an error response instead of hanging the core.
- Sits between m6809_core and the SoC memories/peripherals inside the integration layer.

Parameters:
- N_REGIONS, 4: number of decoded regions.
- ADDR_W, 16: address width.
- DATA_W, 8: data width.
- REGION_BASE, 64'h0001_8000_FF00_0000: packed bases; region i at [i*ADDR_W +: ADDR_W].
- REGION_MASK, 64'h0000_8000_FF00_8000: packed masks. Region i hits when (addr & MASK_i) == BASE_i. Region 3 is disabled by default because mask 0 with base 1 never hits.
- REGION_WAIT, 16'h0100: packed 4-bit wait-state count per region.
- REGION_ACK, 4'b0010: bit i=1 means region i also requires dev_ack.
- TIMEOUT, 16: cycles to wait for dev_ack before aborting; 1..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- core_addr  in  ADDR_W  core address; held stable while a request is pending.
- core_vma  in  1  valid memory access request.
- core_rw_n  in  1  1=read, 0=write.
- core_wdata  in  DATA_W  write data.
- core_rdata  out  DATA_W  registered read data; valid when core_ready=1.
- core_ready  out  1  single-cycle completion pulse.
- dev_sel  out  N_REGIONS  one-hot region select; held through the access.
- dev_addr  out  ADDR_W  registered address.
- dev_wdata  out  DATA_W  registered write data.
- dev_we  out  1  write enable; held with dev_sel.
- dev_strobe  out  1  one-cycle commit pulse on the final access cycle.
- dev_rdata  in  N_REGIONS*DATA_W  packed per-region read data.
- dev_ack  in  N_REGIONS  per-region acknowledge; only used for ACK-mode regions.
- bus_err  out  1  one-cycle pulse coincident with core_ready on an error completion.
- err_addr  out  ADDR_W  address of the most recent error.
- err_count  out  8  saturating count of errors.

Behaviour:
- Reset values: all outputs 0 except core_rdata=0; FSM in IDLE. Reset mid-access abandons the access with no dev_strobe and no core_ready; err_count clears.
- States: IDLE, WAIT, DONE.
- IDLE:
  - core_vma=1 → decode core_addr; the lowest-index hitting region wins.
  - On a hit: register addr/wdata/rw, assert dev_sel[i], set wait_cnt=WAIT_i, set to_cnt=TIMEOUT, go to WAIT.
  - On no hit: go to DONE with an error, rdata=all-ones, err_addr=core_addr.
- WAIT:
  - If wait_cnt≠0, decrement.
  - Else, for a non-ACK region: dev_strobe=1, capture dev_rdata slice i into core_rdata (reads only), go to DONE.
  - Else, for an ACK region with dev_ack[i]=1: same action as the non-ACK case.
  - Else, for an ACK region: decrement to_cnt; when it reaches 0, go to DONE with an error, rdata=all-ones, no dev_strobe.
  - A dev_ack arriving in the same cycle as to_cnt reaching 0 wins; that access is not an error.
- DONE:
  - core_ready=1 for exactly one cycle; bus_err=1 on error.
  - dev_sel and dev_we drop; next state is IDLE unconditionally.
  - The core must change or drop its request after seeing ready.
- Latency from vma sample to core_ready:
  - Non-ACK region: WAIT_i+2 cycles.
  - Unmapped address: 2 cycles.
  - ACK region: at most WAIT_i+TIMEOUT+2 cycles.
- Writes leave core_rdata unchanged.
- err_count increments per error and saturates at 255.
- dev_ack on unselected regions is ignored.

Test Plan:
- Read 0x1234 (region 0, wait 0) with dev_rdata[7:0]=0xA5 → core_ready at cycle 2, core_rdata=0xA5, dev_sel=4'b0001, bus_err=0.
- Write 0x55 to 0x9000 (region 2, wait 1) → dev_we=1, dev_sel=4'b0100, dev_strobe once, core_ready at cycle 3.
- Read 0xFF10 (hits regions 1 and 2) with dev_ack[1] raised 5 cycles after the request → dev_sel=4'b0010 (region 1 wins), ready one cycle after ack, rdata=slice 1.
- Read 0xFF20 with dev_ack never raised → core_ready with bus_err=1, rdata=0xFF, err_addr=0xFF20, err_count=1, no dev_strobe.
- Unmapped address under custom parameters (all masks 0, bases 1) → ready at cycle 2, bus_err=1; 300 such accesses → err_count=255.
- Assert reset during WAIT of a region 2 write → no dev_strobe, outputs 0, FSM IDLE; the next access completes normally.

Source files
------------

// File: rtl/m6809_bus_fabric.sv
// Bus fabric between the m6809 core and N decoded regions: mask/base decode with
// fixed priority, per-region wait states, optional device acknowledge with timeout.
module m6809_bus_fabric #(
    parameter int                          N_REGIONS   = 4,
    parameter int                          ADDR_W      = 16,
    parameter int                          DATA_W      = 8,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = 64'h0001_8000_FF00_0000,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = 64'h0000_8000_FF00_8000,
    parameter logic [N_REGIONS*4-1:0]      REGION_WAIT = 16'h0100,
    parameter logic [N_REGIONS-1:0]        REGION_ACK  = 4'b0010,
    parameter int                          TIMEOUT     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           core_addr,
    input  logic                        core_vma,
    input  logic                        core_rw_n,
    input  logic [DATA_W-1:0]           core_wdata,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        core_ready,
    output logic [N_REGIONS-1:0]        dev_sel,
    output logic [ADDR_W-1:0]           dev_addr,
    output logic [DATA_W-1:0]           dev_wdata,
    output logic                        dev_we,
    output logic                        dev_strobe,
    input  logic [N_REGIONS*DATA_W-1:0] dev_rdata,
    input  logic [N_REGIONS-1:0]        dev_ack,
    output logic                        bus_err,
    output logic [ADDR_W-1:0]           err_addr,
    output logic [7:0]                  err_count
);

    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   sel_idx;
    logic               rw_q;
    logic               miss_q;
    logic [3:0]         wait_cnt;
    logic [7:0]         to_cnt;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               needs_ack;
    logic               acked;
    logic [DATA_W-1:0]  sel_rdata;
    logic               wait_done;
    logic               finish_ok;
    logic               finish_err;

    // Scan from the top down so the lowest-index hitting region is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if ((core_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // An acknowledge arriving on the last timeout cycle takes precedence over the abort.
    always_comb begin
        needs_ack  = REGION_ACK[sel_idx];
        acked      = dev_ack[sel_idx];
        sel_rdata  = dev_rdata[sel_idx*DATA_W +: DATA_W];
        wait_done  = (state == S_WAIT) && (wait_cnt == 4'd0) && !miss_q;
        finish_ok  = wait_done && (!needs_ack || acked);
        finish_err = (state == S_WAIT) &&
                     (miss_q || (wait_done && needs_ack && !acked && (to_cnt == 8'd1)));
    end

    // A miss still passes through WAIT (with no select) so an unmapped access
    // completes with the same two-cycle latency as a zero-wait hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            sel_idx    <= '0;
            rw_q       <= 1'b0;
            miss_q     <= 1'b0;
            wait_cnt   <= '0;
            to_cnt     <= '0;
            core_rdata <= '0;
            core_ready <= 1'b0;
            dev_sel    <= '0;
            dev_addr   <= '0;
            dev_wdata  <= '0;
            dev_we     <= 1'b0;
            dev_strobe <= 1'b0;
            bus_err    <= 1'b0;
            err_addr   <= '0;
            err_count  <= '0;
        end else begin
            core_ready <= 1'b0;
            bus_err    <= 1'b0;
            dev_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (core_vma) begin
                        dev_addr  <= core_addr;
                        dev_wdata <= core_wdata;
                        rw_q      <= core_rw_n;
                        sel_idx   <= hit_idx;
                        miss_q    <= !hit;
                        wait_cnt  <= hit ? REGION_WAIT[hit_idx*4 +: 4] : 4'd0;
                        to_cnt    <= 8'(TIMEOUT);
                        dev_sel   <= hit ? (N_REGIONS'(1) << hit_idx) : '0;
                        dev_we    <= hit && !core_rw_n;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (finish_ok) begin
                        dev_strobe <= 1'b1;
                        core_ready <= 1'b1;
                        if (rw_q) begin
                            core_rdata <= sel_rdata;
                        end
                        state <= S_DONE;
                    end else if (finish_err) begin
                        core_ready <= 1'b1;
                        bus_err    <= 1'b1;
                        core_rdata <= '1;
                        err_addr   <= dev_addr;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 1'b1;
                        end
                        state <= S_DONE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    dev_sel <= '0;
                    dev_we  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m6809_bus_fabric.sv
// Directed bench for m6809_bus_fabric: default map instance plus an all-unmapped instance.
module tb_m6809_bus_fabric;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] core_addr;
    logic        core_vma;
    logic        u_vma;
    logic        core_rw_n;
    logic [7:0]  core_wdata;
    logic [31:0] dev_rdata;
    logic [3:0]  dev_ack;

    logic [7:0]  core_rdata, u_core_rdata;
    logic        core_ready, u_core_ready;
    logic [3:0]  dev_sel, u_dev_sel;
    logic [15:0] dev_addr, u_dev_addr;
    logic [7:0]  dev_wdata, u_dev_wdata;
    logic        dev_we, u_dev_we;
    logic        dev_strobe, u_dev_strobe;
    logic        bus_err, u_bus_err;
    logic [15:0] err_addr, u_err_addr;
    logic [7:0]  err_count, u_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    int          lat;
    int          n_strobe;
    logic [3:0]  s_sel;
    logic [3:0]  r_sel;
    logic [7:0]  r_rdata;
    logic        r_we;
    logic        r_err;
    logic        post_ready;
    logic [3:0]  post_sel;

    always #5 clk = ~clk;

    m6809_bus_fabric dut (
        .clk        (clk),
        .reset      (reset),
        .core_addr  (core_addr),
        .core_vma   (core_vma),
        .core_rw_n  (core_rw_n),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ready (core_ready),
        .dev_sel    (dev_sel),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_we     (dev_we),
        .dev_strobe (dev_strobe),
        .dev_rdata  (dev_rdata),
        .dev_ack    (dev_ack),
        .bus_err    (bus_err),
        .err_addr   (err_addr),
        .err_count  (err_count)
    );

    m6809_bus_fabric #(
        .REGION_BASE (64'h0001_0001_0001_0001),
        .REGION_MASK (64'h0000_0000_0000_0000)
    ) dut_unmapped (
        .clk        (clk),
        .reset      (reset),
        .core_addr  (core_addr),
        .core_vma   (u_vma),
        .core_rw_n  (core_rw_n),
        .core_wdata (core_wdata),
        .core_rdata (u_core_rdata),
        .core_ready (u_core_ready),
        .dev_sel    (u_dev_sel),
        .dev_addr   (u_dev_addr),
        .dev_wdata  (u_dev_wdata),
        .dev_we     (u_dev_we),
        .dev_strobe (u_dev_strobe),
        .dev_rdata  (dev_rdata),
        .dev_ack    (dev_ack),
        .bus_err    (u_bus_err),
        .err_addr   (u_err_addr),
        .err_count  (u_err_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one access, count cycles to core_ready (bounded), optionally raise dev_ack
    // at a given cycle, then step once more to see the DONE -> IDLE cleanup.
    task automatic apply_stimulus(input bit use_alt, input logic [15:0] addr, input logic rw_n,
                                  input logic [7:0] wdata, input int ack_cycle, input logic [3:0] ack_val);
        bit done;
        core_addr  = addr;
        core_rw_n  = rw_n;
        core_wdata = wdata;
        dev_ack    = 4'b0000;
        if (use_alt) u_vma = 1'b1;
        else core_vma = 1'b1;
        lat      = 0;
        n_strobe = 0;
        done     = 1'b0;
        s_sel    = 4'hx;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (lat == ack_cycle) dev_ack = ack_val;
            if (lat == 1) s_sel = use_alt ? u_dev_sel : dev_sel;
            if (use_alt ? u_dev_strobe : dev_strobe) n_strobe++;
            if (use_alt ? u_core_ready : core_ready) begin
                done    = 1'b1;
                r_sel   = use_alt ? u_dev_sel : dev_sel;
                r_rdata = use_alt ? u_core_rdata : core_rdata;
                r_we    = use_alt ? u_dev_we : dev_we;
                r_err   = use_alt ? u_bus_err : bus_err;
            end
        end
        core_vma = 1'b0;
        u_vma    = 1'b0;
        dev_ack  = 4'b0000;
        if (!done) lat = -1;
        step();
        post_ready = use_alt ? u_core_ready : core_ready;
        post_sel   = use_alt ? u_dev_sel : dev_sel;
        if (use_alt ? u_dev_strobe : dev_strobe) n_strobe++;
    endtask

    initial begin
        int bad_lat;
        int strobes_in_reset;

        reset      = 1'b1;
        core_addr  = 16'h0000;
        core_vma   = 1'b0;
        u_vma      = 1'b0;
        core_rw_n  = 1'b1;
        core_wdata = 8'h00;
        dev_ack    = 4'b0000;
        dev_rdata  = {8'hD3, 8'hC2, 8'h3C, 8'hA5};
        step();
        step();
        check_output("rst_ready", core_ready, 1'b0);
        check_output("rst_sel", dev_sel, 4'b0000);
        check_output("rst_rdata", core_rdata, 8'h00);
        check_output("rst_errcnt", err_count, 8'h00);
        check_output("rst_strobe", dev_strobe, 1'b0);
        reset = 1'b0;
        step();

        $display("[TB] read 0x1234 region 0");
        apply_stimulus(1'b0, 16'h1234, 1'b1, 8'h00, 0, 4'b0000);
        check_output("r0_latency", lat, 2);
        check_output("r0_rdata", r_rdata, 8'hA5);
        check_output("r0_sel", r_sel, 4'b0001);
        check_output("r0_err", r_err, 1'b0);
        check_output("r0_strobes", n_strobe, 1);
        check_output("r0_ready_pulse", post_ready, 1'b0);
        check_output("r0_sel_drop", post_sel, 4'b0000);

        $display("[TB] write 0x55 to 0x9000 region 2");
        apply_stimulus(1'b0, 16'h9000, 1'b0, 8'h55, 0, 4'b0000);
        check_output("w2_latency", lat, 3);
        check_output("w2_sel", r_sel, 4'b0100);
        check_output("w2_we", r_we, 1'b1);
        check_output("w2_wdata", dev_wdata, 8'h55);
        check_output("w2_addr", dev_addr, 16'h9000);
        check_output("w2_strobes", n_strobe, 1);
        check_output("w2_rdata_kept", r_rdata, 8'hA5);
        check_output("w2_err", r_err, 1'b0);

        $display("[TB] read 0xFF10 ack region, ack at cycle 5");
        apply_stimulus(1'b0, 16'hFF10, 1'b1, 8'h00, 5, 4'b0010);
        check_output("a1_sel_wait", s_sel, 4'b0010);
        check_output("a1_latency", lat, 6);
        check_output("a1_rdata", r_rdata, 8'h3C);
        check_output("a1_err", r_err, 1'b0);
        check_output("a1_strobes", n_strobe, 1);

        $display("[TB] read 0xFF20 ack never on the selected region");
        apply_stimulus(1'b0, 16'hFF20, 1'b1, 8'h00, 3, 4'b1101);
        check_output("to_latency", lat, 17);
        check_output("to_err", r_err, 1'b1);
        check_output("to_rdata", r_rdata, 8'hFF);
        check_output("to_err_addr", err_addr, 16'hFF20);
        check_output("to_err_count", err_count, 8'd1);
        check_output("to_strobes", n_strobe, 0);

        $display("[TB] read 0xFF30 ack on the last timeout cycle");
        apply_stimulus(1'b0, 16'hFF30, 1'b1, 8'h00, 16, 4'b0010);
        check_output("tl_latency", lat, 17);
        check_output("tl_err", r_err, 1'b0);
        check_output("tl_rdata", r_rdata, 8'h3C);
        check_output("tl_err_count", err_count, 8'd1);
        check_output("tl_strobes", n_strobe, 1);

        $display("[TB] reset during WAIT of a region 2 write");
        core_addr  = 16'h8004;
        core_rw_n  = 1'b0;
        core_wdata = 8'h77;
        core_vma   = 1'b1;
        step();
        check_output("rw_sel_wait", dev_sel, 4'b0100);
        reset    = 1'b1;
        core_vma = 1'b0;
        #1;
        check_output("rw_sel", dev_sel, 4'b0000);
        check_output("rw_we", dev_we, 1'b0);
        check_output("rw_ready", core_ready, 1'b0);
        check_output("rw_errcnt", err_count, 8'h00);
        check_output("rw_rdata", core_rdata, 8'h00);
        strobes_in_reset = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (dev_strobe || core_ready) strobes_in_reset++;
            if (i == 1) reset = 1'b0;
        end
        check_output("rw_no_strobe", strobes_in_reset, 0);
        apply_stimulus(1'b0, 16'h0010, 1'b1, 8'h00, 0, 4'b0000);
        check_output("rw_next_latency", lat, 2);
        check_output("rw_next_rdata", r_rdata, 8'hA5);
        check_output("rw_next_sel", r_sel, 4'b0001);

        $display("[TB] unmapped accesses on the all-miss instance");
        apply_stimulus(1'b1, 16'h1234, 1'b1, 8'h00, 0, 4'b0000);
        check_output("um_latency", lat, 2);
        check_output("um_err", r_err, 1'b1);
        check_output("um_rdata", r_rdata, 8'hFF);
        check_output("um_err_addr", u_err_addr, 16'h1234);
        check_output("um_err_count", u_err_count, 8'd1);
        check_output("um_sel", s_sel, 4'b0000);
        check_output("um_strobes", n_strobe, 0);
        bad_lat = 0;
        for (int i = 1; i < 300; i++) begin
            apply_stimulus(1'b1, 16'(i * 7), 1'b1, 8'h00, 0, 4'b0000);
            if (lat != 2 || !r_err) bad_lat++;
            if (i == 253) check_output("um_err_count_254", u_err_count, 8'd254);
        end
        check_output("um_bad_latency", bad_lat, 0);
        check_output("um_err_count_sat", u_err_count, 8'd255);
        check_output("um_main_untouched", err_count, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
